// File: rtl/viterbi_ber_checker.sv
// Aligns decoder output to a history of encoder input, then counts good/bad bits and watches for loss of lock.
// All outputs registered, updated 1 clk after the enabled sample; no backpressure, en alone gates progress.
module viterbi_ber_checker #(
    parameter int MAX_LAT  = 64,
    parameter int SYNC_WIN = 32,
    parameter int SYNC_THR = 2,
    parameter int LOSS_WIN = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16,
    localparam int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tx_bit,
    input  logic             rx_bit,
    input  logic             fixed_mode,
    input  logic [LW-1:0]    fixed_lat,
    input  logic             clear,
    output logic             locked,
    output logic [LW-1:0]    lat_o,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             mismatch,
    output logic             sat
);

    localparam int FW  = $clog2(MAX_LAT + 2);
    localparam int WW  = $clog2(SYNC_WIN + 1);
    localparam int LSW = $clog2(LOSS_WIN + 1);
    localparam int LEW = $clog2(LOSS_THR + 2);

    localparam logic [LW-1:0]    LAT_MAX  = LW'(MAX_LAT);
    localparam logic [FW-1:0]    FILL_MAX = FW'(MAX_LAT + 1);
    localparam logic [WW-1:0]    SWIN     = WW'(SYNC_WIN);
    localparam logic [WW-1:0]    STHR     = WW'(SYNC_THR);
    localparam logic [LSW-1:0]   LWIN     = LSW'(LOSS_WIN);
    localparam logic [LEW-1:0]   LTHR1    = LEW'(LOSS_THR + 1);
    localparam logic [CNT_W-1:0] CMAX     = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCKED} state_t;

    state_t             state_q, state_d, cur_st;
    logic [MAX_LAT-1:0] hist_q, hist_d;
    logic [MAX_LAT:0]   dvec;
    logic [FW-1:0]      fill_q, fill_d;
    logic [LW-1:0]      lat_q, lat_d, fix_lat;
    logic [WW-1:0]      win_q, win_d, win_n, err_q, err_d, err_n;
    logic [LSW-1:0]     lwin_q, lwin_d, lwin_n;
    logic [LEW-1:0]     lerr_q, lerr_d, lerr_n;
    logic [CNT_W-1:0]   good_q, good_d, bad_q, bad_d, wrap_q, wrap_d;
    logic               mismatch_q, mismatch_d, sat_q, sat_d;
    logic               locked_q, locked_d, fixed_q, fixed_d;
    logic               cmp_vld, miss;

    // dvec[k] is the tx bit from k enabled cycles ago, dvec[0] the live one
    assign dvec    = {hist_q, tx_bit};
    assign cmp_vld = en && (fill_q >= FW'(lat_q));
    assign miss    = rx_bit ^ dvec[lat_q];
    assign win_n   = win_q + WW'(1);
    assign err_n   = err_q + WW'(miss);
    assign lwin_n  = lwin_q + LSW'(1);
    assign lerr_n  = lerr_q + LEW'(miss);
    assign fix_lat = (fixed_lat > LAT_MAX) ? LAT_MAX : fixed_lat;

    always_comb begin
        cur_st     = state_q;
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        lat_d      = lat_q;
        win_d      = win_q;
        err_d      = err_q;
        lwin_d     = lwin_q;
        lerr_d     = lerr_q;
        good_d     = good_q;
        bad_d      = bad_q;
        wrap_d     = wrap_q;
        mismatch_d = 1'b0;
        sat_d      = sat_q;
        fixed_d    = fixed_q;
        // IDLE in free-running mode behaves as the first search cycle
        if (state_q == ST_IDLE && !fixed_mode) begin
            cur_st = ST_SEARCH;
        end
        state_d = cur_st;

        if (clear) begin
            state_d = ST_IDLE;
            lat_d   = '0;
            win_d   = '0;
            err_d   = '0;
            lwin_d  = '0;
            lerr_d  = '0;
            good_d  = '0;
            bad_d   = '0;
            wrap_d  = '0;
            sat_d   = 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                fixed_d = fixed_mode;
                if (fixed_mode) begin
                    state_d = ST_LOCKED;
                    lat_d   = fix_lat;
                    lwin_d  = '0;
                    lerr_d  = '0;
                end
            end
            if (en) begin
                hist_d = dvec[MAX_LAT-1:0];
                if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
            end
            if (cmp_vld && cur_st == ST_SEARCH) begin
                win_d = win_n;
                err_d = err_n;
                if (win_n == SWIN) begin
                    win_d = '0;
                    err_d = '0;
                    if (err_n <= STHR) begin
                        state_d = ST_LOCKED;
                        lwin_d  = '0;
                        lerr_d  = '0;
                    end else if (lat_q == LAT_MAX) begin
                        lat_d = '0;
                        if (wrap_q != CMAX) wrap_d = wrap_q + CNT_W'(1);
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
            end else if (cmp_vld && cur_st == ST_LOCKED) begin
                mismatch_d = miss;
                if (miss) begin
                    if (bad_q != CMAX) bad_d = bad_q + CNT_W'(1);
                end else if (good_q != CMAX) begin
                    good_d = good_q + CNT_W'(1);
                end
                if (!fixed_q) begin
                    lwin_d = lwin_n;
                    lerr_d = lerr_n;
                    if (lerr_n == LTHR1) begin
                        state_d = ST_SEARCH;
                        lat_d   = '0;
                        win_d   = '0;
                        err_d   = '0;
                        lwin_d  = '0;
                        lerr_d  = '0;
                    end else if (lwin_n == LWIN) begin
                        lwin_d = '0;
                        lerr_d = '0;
                    end
                end
            end
            sat_d = sat_q | (good_d == CMAX) | (bad_d == CMAX);
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hist_q     <= '0;
            fill_q     <= '0;
            lat_q      <= '0;
            win_q      <= '0;
            err_q      <= '0;
            lwin_q     <= '0;
            lerr_q     <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            wrap_q     <= '0;
            mismatch_q <= 1'b0;
            sat_q      <= 1'b0;
            locked_q   <= 1'b0;
            fixed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            lat_q      <= lat_d;
            win_q      <= win_d;
            err_q      <= err_d;
            lwin_q     <= lwin_d;
            lerr_q     <= lerr_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            wrap_q     <= wrap_d;
            mismatch_q <= mismatch_d;
            sat_q      <= sat_d;
            locked_q   <= locked_d;
            fixed_q    <= fixed_d;
        end
    end

    assign locked   = locked_q;
    assign lat_o    = lat_q;
    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
    assign wrap_cnt = wrap_q;
    assign mismatch = mismatch_q;
    assign sat      = sat_q;

endmodule
